// File: rtl/gray_readout_pkg.sv
// Shared constants and FSM state encoding for the Gray-count readout block.
package gray_readout_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StConv  = 2'b01,
    StValid = 2'b10
  } state_e;

endpackage

// File: rtl/gray_serial_conv.sv
// Serial Gray-to-binary datapath: captures a Gray word and resolves one bit per step, MSB first.
module gray_serial_conv
  import gray_readout_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_master,
  input  logic             rstb,
  input  logic             capture,
  input  logic             step,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] bin_next,
  output logic             last
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_shift;
  logic [IdxW-1:0]  idx_q;

  // bin_shift[i] is bin_q[i+1]; the MSB sees a zero, so bin[MSB] = g[MSB].
  always_comb begin
    bin_shift       = bin_q >> 1;
    bin_next        = bin_q;
    bin_next[idx_q] = bin_shift[idx_q] ^ gray_q[idx_q];
    last            = (idx_q == '0);
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      gray_q <= '0;
      bin_q  <= '0;
      idx_q  <= '0;
    end else if (capture) begin
      gray_q <= gray_in;
      bin_q  <= '0;
      idx_q  <= IdxW'(WIDTH - 1);
    end else if (step) begin
      bin_q <= bin_next;
      if (idx_q != '0) begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  assign bin = bin_q;

endmodule

// File: rtl/gray_readout.sv
// Gray-count readout: samples a Gray count, converts it serially, and presents binary value
// plus delta from the last accepted value behind a valid/ready handshake.
module gray_readout
  import gray_readout_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_master,
  input  logic             rstb,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             sample_req,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] delta_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  state_e           state_q;
  logic [WIDTH-1:0] delta_q;
  logic [WIDTH-1:0] prev_q;
  logic             valid_q;
  logic             busy_q;
  logic             overrun_q;

  logic             capture;
  logic             step;
  logic             drop;
  logic             last;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_next;

  always_comb begin
    capture = sample_req &&
              ((state_q == StIdle) || ((state_q == StValid) && out_ready));
    step    = (state_q == StConv);
    drop    = sample_req &&
              ((state_q == StConv) || ((state_q == StValid) && !out_ready));
  end

  gray_serial_conv #(
    .WIDTH (WIDTH)
  ) u_conv (
    .clk_master (clk_master),
    .rstb       (rstb),
    .capture    (capture),
    .step       (step),
    .gray_in    (gray_in),
    .bin        (bin),
    .bin_next   (bin_next),
    .last       (last)
  );

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state_q   <= StIdle;
      delta_q   <= '0;
      prev_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // A drop on the same edge as a clear keeps the flag set.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (ovr_clr) begin
        overrun_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (sample_req) begin
            state_q <= StConv;
            busy_q  <= 1'b1;
          end
        end
        StConv: begin
          if (last) begin
            state_q <= StValid;
            valid_q <= 1'b1;
            delta_q <= bin_next - prev_q;
          end
        end
        StValid: begin
          if (out_ready) begin
            prev_q  <= bin;
            valid_q <= 1'b0;
            if (sample_req) begin
              state_q <= StConv;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bin_out   = bin;
  assign delta_out = delta_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/gray_readout.md
GRAY_READOUT -- requirements
Module: gray_readout

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning the bit width of the sampled Gray count.
REQ-002 SHALL provide port clk_master  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rstb  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port gray_in  input  WIDTH  Gray-coded count from the upstream Gray counter tree, synchronous to clk_master.
REQ-005 SHALL provide port sample_req  input  1  request to capture gray_in; level sampled each edge.
REQ-006 SHALL provide port out_ready  input  1  consumer accepts the current result.
REQ-007 SHALL provide port ovr_clr  input  1  clears the sticky overrun flag.
REQ-008 SHALL provide port bin_out  output  WIDTH  binary value of the captured count.
REQ-009 SHALL provide port delta_out  output  WIDTH  bin_out minus previously accepted bin_out, modulo 2^WIDTH.
REQ-010 SHALL provide port out_valid  output  1  bin_out/delta_out hold a valid result.
REQ-011 SHALL provide port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL provide port overrun  output  1  sticky flag; a sample request was dropped.

Function
REQ-013 SHALL implement states IDLE, CONV and VALID.
REQ-014 In IDLE with sample_req=1, SHALL capture gray_in into gray_q, set the bit index to WIDTH-1, and enter CONV on that edge (capture edge E0).
REQ-015 In CONV, SHALL resolve one bit per edge, MSB first: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1] XOR g[i].
REQ-016 SHALL complete conversion on edge E_WIDTH, where it enters VALID and loads delta_out = bin - prev_bin (WIDTH-bit wrap, no carry out).
REQ-017 SHALL assert out_valid exactly WIDTH cycles after E0 and keep it high, with bin_out and delta_out stable, until the handshake completes.
REQ-018 On an edge with out_valid=1 and out_ready=1, SHALL load prev_bin<=bin_out and deassert out_valid.
REQ-019 If sample_req=1 on the same edge as REQ-018, SHALL capture gray_in and go directly to CONV (back-to-back); otherwise SHALL go to IDLE.
REQ-020 Any other sample_req=1 while in CONV, or in VALID without out_ready, SHALL be dropped and SHALL set overrun.
REQ-021 ovr_clr=1 SHALL clear overrun; if a drop occurs on the same edge, set SHALL win.
REQ-022 gray_in SHALL be ignored outside capture edges; gray_q SHALL stay constant during CONV.
REQ-023 bin_out SHALL show partially converted bits during CONV; consumers SHALL use bin_out only when out_valid=1.
REQ-024 After reset, prev_bin=0, so the first delta_out equals the first bin_out.

Reset
REQ-025 rstb low SHALL immediately force state IDLE, gray_q=0, bin_out=0, delta_out=0, prev_bin=0, bit index=0, out_valid=0, busy=0 and overrun=0, independent of clk_master.
REQ-026 Reset asserted mid-CONV or in VALID SHALL discard the result with no handshake.
REQ-027 After rstb deasserts, the first edge SHALL behave as in IDLE.

Structure
REQ-028 SHALL place the state encoding (IDLE=2'b00, CONV=2'b01, VALID=2'b10) and the default WIDTH constant in shared package gray_readout_pkg.
REQ-029 SHALL split the serial Gray-to-binary datapath (gray_q, bit index, bin register) into sub-module gray_serial_conv, with the FSM, delta and handshake logic in gray_readout.

Verification (WIDTH=8)
REQ-030 Reset then sample gray_in=8'h0C: out_valid 8 cycles after E0, bin_out=8'h08, delta_out=8'h08.
REQ-031 Accept 8'hFF (gray 8'h80), then sample gray 8'h01: bin_out=8'h01, delta_out=8'h02 (wrap).
REQ-032 Hold out_ready=0 for 5 cycles in VALID with sample_req pulsed: outputs stable, overrun=1, request dropped; ovr_clr then clears overrun.
REQ-033 sample_req with out_ready on the completion edge: next result appears 8 cycles later with no IDLE cycle in between.
REQ-034 rstb pulsed low at CONV bit 3: all outputs 0 asynchronously, state IDLE, the next sample converts correctly with delta computed from prev_bin=0.
